pdn_rail_sequencer: RTL and testbench

Power-up/power-down sequencer that drives the enables of the supply rails feeding the PDN top level (VDD1..VDD6 by default). It sits directly upstream of the rail inputs of the power network. Rails turn on in ascending index order, each gated by its power-good (PG) input and a settle delay. They turn off in descending order with a fixed inter-rail delay. A PG timeout or an unexpected PG loss forces all rails off and latches a fault.

---
 rtl/pdn_rail_sequencer.sv | 207 ++++++++++++++++++++
 tb/tb_pdn_rail_sequencer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/pdn_rail_sequencer.sv
// Power rail sequencer: ascending PG-gated ramp-up with settle delay, descending timed
// ramp-down, and fault latching on PG timeout or PG loss of an enabled rail.
module pdn_rail_sequencer #(
    parameter int unsigned NUM_RAILS  = 6,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned SETTLE_CYC = 4,
    parameter int unsigned OFF_DELAY  = 4,
    parameter int unsigned PG_TIMEOUT = 1000,
    localparam int unsigned IDX_W     = $clog2(NUM_RAILS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pwr_on_req,
    input  logic                 pwr_off_req,
    input  logic                 fault_clr,
    input  logic [NUM_RAILS-1:0] rail_pg,
    output logic [NUM_RAILS-1:0] rail_en,
    output logic                 seq_busy,
    output logic                 all_good,
    output logic                 fault,
    output logic [IDX_W-1:0]     fault_rail
);

    typedef enum logic [2:0] {
        StIdle,
        StRampUp,
        StSettle,
        StAllOn,
        StRampDown,
        StFault
    } state_t;

    localparam logic [CNT_W-1:0]     SettleLast  = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0]     OffLast     = CNT_W'(OFF_DELAY - 1);
    localparam logic [CNT_W-1:0]     TimeoutLast = CNT_W'(PG_TIMEOUT - 1);
    localparam logic [IDX_W-1:0]     LastIdx     = IDX_W'(NUM_RAILS - 1);
    localparam logic [NUM_RAILS-1:0] OneRail     = NUM_RAILS'(1);

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [NUM_RAILS-1:0]   rail_en_q, rail_en_d;
    logic                   seq_busy_q, seq_busy_d;
    logic                   all_good_q, all_good_d;
    logic                   fault_q, fault_d;
    logic [IDX_W-1:0]       fault_rail_q, fault_rail_d;

    logic [NUM_RAILS-1:0]   idx_oh;
    logic [NUM_RAILS-1:0]   pg_fail;
    logic [IDX_W-1:0]       fail_idx;
    logic                   pg_cur;
    logic                   pg_monitor;

    // PG-loss detection: enabled rails without PG, except the rail still ramping.
    always_comb begin
        idx_oh     = OneRail << idx_q;
        pg_cur     = |(rail_pg & idx_oh);
        pg_monitor = (state_q == StRampUp) || (state_q == StSettle) || (state_q == StAllOn);
        pg_fail    = rail_en_q & ~rail_pg;
        if (state_q == StRampUp) begin
            pg_fail = pg_fail & ~idx_oh;
        end
        if (!pg_monitor) begin
            pg_fail = '0;
        end
        // Scan downwards so the lowest failing rail wins.
        fail_idx = '0;
        for (int i = NUM_RAILS - 1; i >= 0; i--) begin
            if (pg_fail[i]) begin
                fail_idx = IDX_W'(i);
            end
        end
    end

    // Next-state and next-output logic for the sequencer FSM.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        rail_en_d    = rail_en_q;
        fault_rail_d = fault_rail_q;

        if (|pg_fail) begin
            // PG loss outranks every other transition in a monitored state.
            state_d      = StFault;
            rail_en_d    = '0;
            cnt_d        = '0;
            fault_rail_d = fail_idx;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (pwr_on_req) begin
                        state_d   = StRampUp;
                        idx_d     = '0;
                        cnt_d     = '0;
                        rail_en_d = OneRail;
                    end
                end
                StRampUp: begin
                    if (!pg_cur && cnt_q == TimeoutLast) begin
                        state_d      = StFault;
                        rail_en_d    = '0;
                        cnt_d        = '0;
                        fault_rail_d = idx_q;
                    end else if (pwr_off_req) begin
                        // Abort: current rail is the highest enabled one.
                        state_d   = StRampDown;
                        rail_en_d = rail_en_q & ~idx_oh;
                        cnt_d     = '0;
                    end else if (pg_cur) begin
                        state_d = StSettle;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                StSettle: begin
                    if (pwr_off_req) begin
                        state_d   = StRampDown;
                        rail_en_d = rail_en_q & ~idx_oh;
                        cnt_d     = '0;
                    end else if (cnt_q == SettleLast) begin
                        cnt_d = '0;
                        if (idx_q == LastIdx) begin
                            state_d = StAllOn;
                        end else begin
                            state_d   = StRampUp;
                            rail_en_d = rail_en_q | (idx_oh << 1);
                            idx_d     = idx_q + 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                StAllOn: begin
                    if (pwr_off_req) begin
                        state_d   = StRampDown;
                        idx_d     = LastIdx;
                        rail_en_d = rail_en_q & ~(OneRail << LastIdx);
                        cnt_d     = '0;
                    end
                end
                StRampDown: begin
                    if (cnt_q == OffLast) begin
                        cnt_d = '0;
                        if (idx_q != '0) begin
                            rail_en_d = rail_en_q & ~(idx_oh >> 1);
                            idx_d     = idx_q - 1'b1;
                        end else begin
                            state_d = StIdle;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                StFault: begin
                    if (fault_clr) begin
                        state_d = StIdle;
                        idx_d   = '0;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d   = StIdle;
                    rail_en_d = '0;
                    idx_d     = '0;
                    cnt_d     = '0;
                end
            endcase
        end

        seq_busy_d = (state_d == StRampUp) || (state_d == StSettle) ||
                     (state_d == StRampDown);
        all_good_d = (state_d == StAllOn);
        fault_d    = (state_d == StFault);
    end

    // State and registered outputs; reset drops every enable at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            idx_q        <= '0;
            rail_en_q    <= '0;
            seq_busy_q   <= 1'b0;
            all_good_q   <= 1'b0;
            fault_q      <= 1'b0;
            fault_rail_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            rail_en_q    <= rail_en_d;
            seq_busy_q   <= seq_busy_d;
            all_good_q   <= all_good_d;
            fault_q      <= fault_d;
            fault_rail_q <= fault_rail_d;
        end
    end

    assign rail_en    = rail_en_q;
    assign seq_busy   = seq_busy_q;
    assign all_good   = all_good_q;
    assign fault      = fault_q;
    assign fault_rail = fault_rail_q;

endmodule

// File: tb/tb_pdn_rail_sequencer.sv
// Directed bench for pdn_rail_sequencer: a per-cycle vector table plus hand-written
// sequences for full ramp-up/down, PG timeout, PG loss and asynchronous reset.
module tb_pdn_rail_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       on_req = 1'b0;
    logic       off_req = 1'b0;
    logic       clr = 1'b0;
    logic [5:0] pg = '0;
    logic [5:0] rail_en;
    logic       seq_busy;
    logic       all_good;
    logic       fault;
    logic [2:0] fault_rail;

    int n_cmp  = 0;
    int n_fail = 0;

    pdn_rail_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .pwr_on_req  (on_req),
        .pwr_off_req (off_req),
        .fault_clr   (clr),
        .rail_pg     (pg),
        .rail_en     (rail_en),
        .seq_busy    (seq_busy),
        .all_good    (all_good),
        .fault       (fault),
        .fault_rail  (fault_rail)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       on;
        logic       off;
        logic [5:0] pg;
        logic [5:0] en;
        logic       busy;
        logic       good;
    } vec_t;

    vec_t vt[28];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [5:0] mask(input int k);
        logic [6:0] m;
        m = (7'd1 << k) - 7'd1;
        return m[5:0];
    endfunction

    task automatic setv(input int i, input logic o, input logic f, input logic [5:0] p,
                        input logic [5:0] e, input logic b, input logic g);
        vt[i].on = o; vt[i].off = f; vt[i].pg = p;
        vt[i].en = e; vt[i].busy = b; vt[i].good = g;
    endtask

    // Power-up ramping the first n rails; each PG rises 3 cycles after its enable.
    task automatic up_to(input int n, input bit check);
        on_req = 1'b1;
        step();
        on_req = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (check) chk("up_en", {26'd0, rail_en}, {26'd0, mask(i + 1)});
            step();
            step();
            pg[i] = 1'b1;
            step();
            step();
            step();
            step();
            if (check) chk("up_hold", {26'd0, rail_en}, {26'd0, mask(i + 1)});
            if (check) chk("up_nofault", {31'd0, fault}, 32'd0);
            step();
        end
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        #3;
        step();
        rst = 1'b0;
        on_req = 1'b0; off_req = 1'b0; clr = 1'b0; pg = '0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Per-cycle table: abort during SETTLE of rail 2 and simultaneous requests.
        setv(0,  0, 1, 6'h00, 6'h00, 0, 0);
        setv(1,  1, 1, 6'h00, 6'h01, 1, 0);
        setv(2,  0, 0, 6'h00, 6'h01, 1, 0);
        setv(3,  0, 0, 6'h01, 6'h01, 1, 0);
        setv(4,  0, 0, 6'h01, 6'h01, 1, 0);
        setv(5,  0, 0, 6'h01, 6'h01, 1, 0);
        setv(6,  0, 0, 6'h01, 6'h01, 1, 0);
        setv(7,  0, 0, 6'h01, 6'h03, 1, 0);
        setv(8,  0, 0, 6'h03, 6'h03, 1, 0);
        setv(9,  0, 0, 6'h03, 6'h03, 1, 0);
        setv(10, 0, 0, 6'h03, 6'h03, 1, 0);
        setv(11, 0, 0, 6'h03, 6'h03, 1, 0);
        setv(12, 0, 0, 6'h03, 6'h07, 1, 0);
        setv(13, 0, 0, 6'h07, 6'h07, 1, 0);
        setv(14, 0, 1, 6'h07, 6'h03, 1, 0);
        setv(15, 0, 0, 6'h00, 6'h03, 1, 0);
        setv(16, 0, 0, 6'h00, 6'h03, 1, 0);
        setv(17, 0, 0, 6'h00, 6'h03, 1, 0);
        setv(18, 0, 0, 6'h00, 6'h01, 1, 0);
        setv(19, 0, 0, 6'h00, 6'h01, 1, 0);
        setv(20, 1, 0, 6'h00, 6'h01, 1, 0);
        setv(21, 0, 0, 6'h00, 6'h01, 1, 0);
        setv(22, 0, 0, 6'h00, 6'h00, 1, 0);
        setv(23, 0, 0, 6'h00, 6'h00, 1, 0);
        setv(24, 0, 0, 6'h00, 6'h00, 1, 0);
        setv(25, 0, 0, 6'h00, 6'h00, 1, 0);
        setv(26, 0, 0, 6'h00, 6'h00, 0, 0);
        setv(27, 1, 1, 6'h00, 6'h01, 1, 0);

        // Reset state, sampled while reset is still asserted.
        rst = 1'b1;
        step();
        step();
        chk("reset_outs", {20'd0, rail_en, seq_busy, all_good, fault, fault_rail},
            32'd0);
        rst = 1'b0;

        for (int i = 0; i < 28; i++) begin
            on_req  = vt[i].on;
            off_req = vt[i].off;
            pg      = vt[i].pg;
            step();
            chk($sformatf("vec[%0d]", i),
                {20'd0, rail_en, seq_busy, all_good, fault, fault_rail},
                {20'd0, vt[i].en, vt[i].busy, vt[i].good, 1'b0, 3'd0});
        end
        on_req = 1'b0; off_req = 1'b0;

        // Nominal ramp-up of all six rails.
        pulse_reset();
        up_to(6, 1'b1);
        chk("allon_en", {26'd0, rail_en}, 32'h3F);
        chk("allon_good", {30'd0, all_good, seq_busy}, 32'h2);
        chk("allon_fault", {31'd0, fault}, 32'd0);

        // Power-down from ALL_ON, 4 cycles between disables.
        off_req = 1'b1;
        step();
        off_req = 1'b0;
        chk("dn_first", {26'd0, rail_en}, 32'h1F);
        for (int k = 4; k >= 0; k--) begin
            step();
            step();
            step();
            chk("dn_hold", {26'd0, rail_en}, {26'd0, mask(k + 1)});
            step();
            chk("dn_step", {26'd0, rail_en}, {26'd0, mask(k)});
        end
        step();
        step();
        step();
        chk("dn_busy_tail", {31'd0, seq_busy}, 32'd1);
        step();
        chk("dn_idle", {30'd0, seq_busy, all_good}, 32'd0);

        // PG timeout on rail 2.
        pg = 6'h03;
        on_req = 1'b1;
        step();
        on_req = 1'b0;
        chk("to_en0", {26'd0, rail_en}, 32'h01);
        for (int k = 0; k < 10; k++) step();
        chk("to_en2", {26'd0, rail_en}, 32'h07);
        for (int k = 0; k < 999; k++) step();
        chk("to_before", {26'd0, rail_en, fault}, {26'd0, 6'h07, 1'b0});
        step();
        chk("to_fault", {20'd0, rail_en, seq_busy, all_good, fault, fault_rail},
            {20'd0, 6'h00, 1'b0, 1'b0, 1'b1, 3'd2});
        step();
        chk("to_hold", {28'd0, fault, fault_rail}, {28'd0, 1'b1, 3'd2});
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("to_clr", {23'd0, rail_en, seq_busy, all_good, fault}, 32'd0);

        // PG loss of rails 4 and 1 together in ALL_ON; lowest index reported.
        pg = '0;
        up_to(6, 1'b0);
        chk("loss_pre", {25'd0, rail_en, all_good}, {25'd0, 6'h3F, 1'b1});
        pg = 6'h2D;
        step();
        chk("loss_fault", {20'd0, rail_en, seq_busy, all_good, fault, fault_rail},
            {20'd0, 6'h00, 1'b0, 1'b0, 1'b1, 3'd1});
        on_req = 1'b1;
        step();
        on_req = 1'b0;
        chk("loss_ignore_on", {25'd0, rail_en, fault}, {25'd0, 6'h00, 1'b1});
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("loss_clr", {31'd0, fault}, 32'd0);

        // Asynchronous reset mid-ramp with rails 0..3 enabled.
        pg = '0;
        up_to(3, 1'b0);
        chk("ar_pre", {25'd0, rail_en, seq_busy}, {25'd0, 6'h0F, 1'b1});
        #2;
        rst = 1'b1;
        #1;
        chk("ar_clear", {24'd0, rail_en, seq_busy, fault}, 32'd0);
        #3;
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
